memory_stage: RTL and testbench

- Y86-64 pipeline memory stage plus the M/W pipeline register.
- Takes the instruction held in the M register, performs the data-memory read or write, and registers the results into the W register.
- The W register outputs feed the write-back stage.
- Also drives the combinational m_valM and m_stat signals for forwarding and hazard control.

---
 rtl/memory_stage.sv | 161 ++++++++++++++++
 tb/tb_memory_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86-64 memory stage with byte-addressed data memory and the M/W pipeline register.
// Optional macro DMEM_ALIGN_CHECK_EN makes any access with addr[2:0] != 0 invalid (SADR).
module memory_stage #(
    parameter int DMEM_BYTES = 1024,
    parameter int ADDR_W     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  M_stat,
    input  logic [3:0]  M_icode,
    input  logic [63:0] M_valE,
    input  logic [63:0] M_valA,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic        W_stall,
    input  logic        W_bubble,
    output logic [63:0] m_valM,
    output logic [2:0]  m_stat,
    output logic [2:0]  W_stat,
    output logic [3:0]  W_icode,
    output logic [63:0] W_valE,
    output logic [63:0] W_valM,
    output logic [3:0]  W_dstE,
    output logic [3:0]  W_dstM
);

    localparam int IW = $clog2(DMEM_BYTES);

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SADR = 3'd3;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    logic [7:0]        mem_q [DMEM_BYTES];

    logic [ADDR_W-1:0] addr;
    logic              rd_class;
    logic              wr_class;
    logic              addr_bad;
    logic              misalign;
    logic              wr_en;
    logic [IW-1:0]     byte_idx [8];
    logic [63:0]       rd_word;

    logic [2:0]  w_stat_d,  w_stat_q;
    logic [3:0]  w_icode_d, w_icode_q;
    logic [63:0] w_vale_d,  w_vale_q;
    logic [63:0] w_valm_d,  w_valm_q;
    logic [3:0]  w_dste_d,  w_dste_q;
    logic [3:0]  w_dstm_d,  w_dstm_q;

    always_comb begin
        rd_class = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ) || (M_icode == I_RET);
        wr_class = (M_icode == I_RMMOVQ) || (M_icode == I_CALL) || (M_icode == I_PUSHQ);
        if ((M_icode == I_POPQ) || (M_icode == I_RET))
            addr = M_valA[ADDR_W-1:0];
        else
            addr = M_valE[ADDR_W-1:0];
`ifdef DMEM_ALIGN_CHECK_EN
        misalign = (addr[2:0] != 3'd0);
`else
        misalign = 1'b0;
`endif
        // Unsigned compare on the full address, so huge values never wrap into range.
        addr_bad = (rd_class || wr_class) &&
                   ((addr > ADDR_W'(DMEM_BYTES - 8)) || misalign);
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            byte_idx[i] = addr[IW-1:0] + IW'(i);
        end
        rd_word = '0;
        for (int i = 0; i < 8; i++) begin
            rd_word[8*i +: 8] = mem_q[byte_idx[i]];
        end
    end

    always_comb begin
        m_valM = (rd_class && !addr_bad) ? rd_word : 64'd0;
        if (M_stat != SAOK)
            m_stat = M_stat;
        else if (addr_bad)
            m_stat = SADR;
        else
            m_stat = M_stat;
        wr_en = wr_class && !addr_bad && (M_stat == SAOK) && !W_stall;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DMEM_BYTES; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[byte_idx[i]] <= M_valA[8*i +: 8];
            end
        end
    end

    // Stall outranks bubble; a bubble reloads the reset (nop) image.
    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        if (!W_stall) begin
            if (W_bubble) begin
                w_stat_d  = SAOK;
                w_icode_d = I_NOP;
                w_vale_d  = 64'd0;
                w_valm_d  = 64'd0;
                w_dste_d  = R_NONE;
                w_dstm_d  = R_NONE;
            end else begin
                w_stat_d  = m_stat;
                w_icode_d = M_icode;
                w_vale_d  = M_valE;
                w_valm_d  = m_valM;
                w_dste_d  = M_dstE;
                w_dstm_d  = M_dstM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_stat_q  <= SAOK;
            w_icode_q <= I_NOP;
            w_vale_q  <= 64'd0;
            w_valm_q  <= 64'd0;
            w_dste_q  <= R_NONE;
            w_dstm_q  <= R_NONE;
        end else begin
            w_stat_q  <= w_stat_d;
            w_icode_q <= w_icode_d;
            w_vale_q  <= w_vale_d;
            w_valm_q  <= w_valm_d;
            w_dste_q  <= w_dste_d;
            w_dstm_q  <= w_dstm_d;
        end
    end

    assign W_stat  = w_stat_q;
    assign W_icode = w_icode_q;
    assign W_valE  = w_vale_q;
    assign W_valM  = w_valm_q;
    assign W_dstE  = w_dste_q;
    assign W_dstM  = w_dstm_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: memory access, range/status, stall/bubble and async reset.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;
    logic        W_stall;
    logic        W_bubble;
    logic [63:0] m_valM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;

    int checks = 0;
    int errors = 0;

    memory_stage #(.DMEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
        .m_valM(m_valM), .m_stat(m_stat),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply an M instruction shortly after a rising edge and let it settle.
    task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
        M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; W_stall = 1'b0; W_bubble = 1'b0;
        M_stat = 3'd1; M_icode = 4'h1; M_valE = '0; M_valA = '0; M_dstE = 4'hF; M_dstM = 4'hF;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_W_stat", 64'(W_stat), 64'd1);
        check("rst_W_icode", 64'(W_icode), 64'd1);
        check("rst_W_valE", W_valE, 64'd0);
        check("rst_W_valM", W_valM, 64'd0);
        check("rst_W_dstE", 64'(W_dstE), 64'hF);
        check("rst_W_dstM", 64'(W_dstM), 64'hF);

        // rmmovq then mrmovq at 0x10
        step();
        drive(3'd1, 4'h4, 64'h10, 64'h1122334455667788, 4'hF, 4'hF);
        check("wr_m_stat", 64'(m_stat), 64'd1);
        check("wr_m_valM_zero", m_valM, 64'd0);
        step();
        check("wr_W_icode", 64'(W_icode), 64'd4);
        check("wr_W_valE", W_valE, 64'h10);
        drive(3'd1, 4'h5, 64'h10, 64'h0, 4'hF, 4'h3);
        check("rd_m_valM", m_valM, 64'h1122334455667788);
        step();
        check("rd_W_valM", W_valM, 64'h1122334455667788);
        check("rd_W_dstM", 64'(W_dstM), 64'h3);

        // pushq / popq through the stack pointer
        drive(3'd1, 4'hA, 64'h1F8, 64'hABCD, 4'h4, 4'hF);
        step();
        drive(3'd1, 4'hB, 64'h200, 64'h1F8, 4'h4, 4'h5);
        check("pop_m_valM", m_valM, 64'hABCD);
        step();
        check("pop_W_valM", W_valM, 64'hABCD);
        check("pop_W_valE", W_valE, 64'h200);
        check("pop_W_dstE", 64'(W_dstE), 64'h4);
        check("pop_W_dstM", 64'(W_dstM), 64'h5);

        // Range boundary and exception pass-through
        drive(3'd1, 4'h5, 64'h3FC, 64'h0, 4'hF, 4'h2);
        check("oob_m_stat", 64'(m_stat), 64'd3);
        check("oob_m_valM", m_valM, 64'd0);
        step();
        check("oob_W_stat", 64'(W_stat), 64'd3);
        drive(3'd1, 4'h5, 64'h3F8, 64'h0, 4'hF, 4'h2);
        check("edge_m_stat", 64'(m_stat), 64'd1);
        drive(3'd4, 4'h5, 64'h3FC, 64'h0, 4'hF, 4'h2);
        check("exc_pass_m_stat", 64'(m_stat), 64'd4);
        drive(3'd1, 4'h4, 64'hFFFFFFFFFFFFFFF8, 64'hDEAD, 4'hF, 4'hF);
        check("huge_m_stat", 64'(m_stat), 64'd3);
        step();
        drive(3'd1, 4'h5, 64'h3F8, 64'h0, 4'hF, 4'h2);
        check("huge_no_wrap", m_valM, 64'd0);
        drive(3'd2, 4'h4, 64'h30, 64'h77, 4'hF, 4'hF);
        step();
        drive(3'd1, 4'h5, 64'h30, 64'h0, 4'hF, 4'h2);
        check("halt_no_write", m_valM, 64'd0);
        step();

        // Stall holds W and suppresses the write, even with bubble asserted
        W_stall = 1'b1; W_bubble = 1'b1;
        drive(3'd1, 4'h4, 64'h40, 64'h99, 4'h6, 4'h7);
        step();
        check("stall_W_icode", 64'(W_icode), 64'd5);
        check("stall_W_valE", W_valE, 64'h30);
        W_stall = 1'b0;
        drive(3'd1, 4'h5, 64'h40, 64'h0, 4'h6, 4'h7);
        check("stall_no_write", m_valM, 64'd0);
        step();
        check("bub_W_icode", 64'(W_icode), 64'd1);
        check("bub_W_stat", 64'(W_stat), 64'd1);
        check("bub_W_dstE", 64'(W_dstE), 64'hF);
        check("bub_W_dstM", 64'(W_dstM), 64'hF);
        check("bub_W_valE", W_valE, 64'd0);
        W_bubble = 1'b0;

        // Unaligned access
        drive(3'd1, 4'h4, 64'h10, 64'h0807060504030201, 4'hF, 4'hF);
        step();
        drive(3'd1, 4'h5, 64'h11, 64'h0, 4'hF, 4'h1);
`ifdef DMEM_ALIGN_CHECK_EN
        check("unal_m_stat", 64'(m_stat), 64'd3);
        check("unal_m_valM", m_valM, 64'd0);
`else
        check("unal_m_stat", 64'(m_stat), 64'd1);
        check("unal_m_valM", m_valM, 64'h0008070605040302);
`endif
        step();
        check("pre_rst_W_icode", 64'(W_icode), 64'd5);

        // Asynchronous reset in the middle of a write cycle
        drive(3'd1, 4'h4, 64'h20, 64'h55, 4'h2, 4'h3);
        #2 rst = 1'b1;
        #1;
        check("arst_W_icode", 64'(W_icode), 64'd1);
        check("arst_W_dstM", 64'(W_dstM), 64'hF);
        check("arst_W_valM", W_valM, 64'd0);
        step();
        #2 rst = 1'b0;
        drive(3'd1, 4'h5, 64'h20, 64'h0, 4'hF, 4'h1);
        check("arst_mem20", m_valM, 64'd0);
        drive(3'd1, 4'h5, 64'h10, 64'h0, 4'hF, 4'h1);
        check("arst_mem10", m_valM, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
